// File: rtl/ub_port_arbiter_pkg.sv
// Shared types and constants for the Unified Buffer port arbiter.
package tpu_ub_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int CH_HOST = 0;
    localparam int CH_CTRL = 1;
    localparam int CH_DMA  = 2;
endpackage

// File: rtl/ub_port_arbiter_if.sv
// Requester-side burst handshake plus the UB memory port, bundled for the arbiter.
interface ub_port_arbiter_if
    import tpu_ub_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 9
);
    logic [NUM_CH-1:0]        cmd_valid;
    logic [NUM_CH-1:0]        cmd_ready;
    logic [NUM_CH-1:0]        cmd_we;
    logic [NUM_CH*ADDR_W-1:0] cmd_addr;
    logic [NUM_CH*LEN_W-1:0]  cmd_len;
    logic [NUM_CH-1:0]        wr_valid;
    logic [NUM_CH*DATA_W-1:0] wr_data;
    logic [NUM_CH-1:0]        wr_ready;
    logic [NUM_CH-1:0]        rd_valid;
    logic                     rd_last;
    logic [DATA_W-1:0]        rd_data;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     busy;
    logic [NUM_CH-1:0]        owner;
    logic                     err_tmo;

    // Arbiter side
    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_last, rd_data,
               mem_en, mem_we, mem_addr, mem_wdata, busy, owner, err_tmo
    );

    // Requesters + UB side
    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_last, rd_data,
               mem_en, mem_we, mem_addr, mem_wdata, busy, owner, err_tmo
    );
endinterface

// File: rtl/ub_port_arbiter_rr_arbiter.sv
// Request vector to one-hot grant; fixed priority or round-robin with its own pointer.
module ub_rr_arbiter
    import tpu_ub_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int MODE   = ARB_FIXED,
    parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [PW-1:0]     win
);
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_raw;
    logic [PW-1:0]     win_c;
    logic              found;
    int                idx;

    // Scan from the pointer (RR) or from channel 0 (fixed); first requester wins.
    always_comb begin
        gnt_raw = '0;
        win_c   = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (MODE == ARB_RR) ? ((int'(ptr_q) + i) % NUM_CH) : i;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt_raw[idx] = 1'b1;
                win_c        = PW'(idx);
            end
        end
    end

    // Pointer moves past the winner only when a grant actually happens.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE == ARB_RR && en && found)
            ptr_d = (int'(win_c) == NUM_CH - 1) ? '0 : win_c + 1'b1;
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign gnt = en ? gnt_raw : '0;
    assign win = win_c;
endmodule

// File: rtl/ub_port_arbiter.sv
// Burst arbiter for the single UB port: atomic bursts, write back-pressure,
// tagged read return and a write-stall watchdog.
module ub_port_arbiter
    import tpu_ub_arb_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 9,
    parameter int LEN_W    = 9,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int WR_TMO   = 255
) (
    input logic         clk,
    input logic         rst,
    ub_port_arbiter_if.slave bus
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(WR_TMO + 1) + 1;

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ch_q, ch_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic              err_q, err_d;

    // Read tags: stage k holds beats issued k cycles ago.
    logic [RD_LAT:1]         vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][PW-1:0] ch_pipe_q, ch_pipe_d;
    logic [RD_LAT:1]         last_pipe_q, last_pipe_d;

    logic              arb_en;
    logic [NUM_CH-1:0] gnt;
    logic [PW-1:0]     win;
    logic              issue;
    logic [NUM_CH-1:0] owner_oh;

    // Grants only in IDLE and never while reset is held.
    assign arb_en = (state_q == ARB_IDLE) && !rst;

    ub_rr_arbiter #(.NUM_CH(NUM_CH), .MODE(ARB_MODE), .PW(PW)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (bus.cmd_valid),
        .gnt (gnt),
        .win (win)
    );

    // State and datapath registers, tag pipe included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ch_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            vld_pipe_q  <= '0;
            ch_pipe_q   <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            vld_pipe_q  <= vld_pipe_d;
            ch_pipe_q   <= ch_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    // Next state: latch the winner's burst, step beats, abort on a stalled writer.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|gnt) begin
                    state_d = ARB_BURST;
                    ch_d    = win;
                    we_d    = bus.cmd_we[win];
                    addr_d  = bus.cmd_addr[win*ADDR_W +: ADDR_W];
                    len_d   = bus.cmd_len[win*LEN_W +: LEN_W];
                    beat_d  = '0;
                    wdog_d  = '0;
                end
            end
            ARB_BURST: begin
                if (issue) begin
                    wdog_d = '0;
                    if (beat_q == len_q) begin
                        state_d = ARB_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else if (WR_TMO != 0 && wdog_q == TW'(WR_TMO - 1)) begin
                    state_d = ARB_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: a beat issues every read cycle, or on writer-valid for writes.
    always_comb begin
        issue       = (state_q == ARB_BURST) && (!we_q || bus.wr_valid[ch_q]);
        owner_oh    = (state_q == ARB_BURST) ? (NUM_CH'(1) << ch_q) : '0;
        vld_pipe_d  = '0;
        ch_pipe_d   = '0;
        last_pipe_d = '0;
        vld_pipe_d[1]  = issue && !we_q;
        ch_pipe_d[1]   = ch_q;
        last_pipe_d[1] = (beat_q == len_q);
        for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe_d[k]  = vld_pipe_q[k-1];
            ch_pipe_d[k]   = ch_pipe_q[k-1];
            last_pipe_d[k] = last_pipe_q[k-1];
        end
    end

    assign bus.cmd_ready = gnt;
    assign bus.busy      = (state_q == ARB_BURST);
    assign bus.owner     = owner_oh;
    assign bus.wr_ready  = we_q ? owner_oh : '0;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue && we_q;
    assign bus.mem_addr  = (state_q == ARB_BURST) ? addr_q : '0;
    assign bus.mem_wdata = (issue && we_q) ? bus.wr_data[ch_q*DATA_W +: DATA_W] : '0;
    assign bus.rd_valid  = NUM_CH'(vld_pipe_q[RD_LAT]) << ch_pipe_q[RD_LAT];
    assign bus.rd_last   = vld_pipe_q[RD_LAT] && last_pipe_q[RD_LAT];
    assign bus.rd_data   = vld_pipe_q[RD_LAT] ? bus.mem_rdata : '0;
    assign bus.err_tmo   = err_q;
endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed bench: dut_a = fixed priority, RD_LAT 1, WR_TMO 4;
// dut_b = round-robin, RD_LAT 3, watchdog off.
module tb_ub_port_arbiter;
    localparam int NC = 3;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   wr_cnt_a = 0;
    logic [DW-1:0] pb1, pb2;

    always #5 clk = ~clk;

    ub_port_arbiter_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) ia ();
    ub_port_arbiter_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) ib ();

    ub_port_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW),
                      .RD_LAT(1), .ARB_MODE(0), .WR_TMO(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    ub_port_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW),
                      .RD_LAT(3), .ARB_MODE(1), .WR_TMO(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    // UB content is a fixed function of address
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hD000_0000 | DW'(a);
    endfunction

    // UB models: 1-cycle read for dut_a (plus write counter), 3-cycle for dut_b
    always @(posedge clk) begin
        ia.mem_rdata <= pat(ia.mem_addr);
        if (ia.mem_en && ia.mem_we) wr_cnt_a <= wr_cnt_a + 1;
    end
    always @(posedge clk) begin
        pb1          <= pat(ib.mem_addr);
        pb2          <= pb1;
        ib.mem_rdata <= pb2;
    end

    task automatic set_cmd_a(input int ch, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        ia.cmd_we[ch] = we;
        ia.cmd_addr[ch*AW +: AW] = addr;
        ia.cmd_len[ch*LW +: LW] = len;
    endtask

    task automatic set_cmd_b(input int ch, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        ib.cmd_we[ch] = we;
        ib.cmd_addr[ch*AW +: AW] = addr;
        ib.cmd_len[ch*LW +: LW] = len;
    endtask

    task automatic test_reset;
        logic [89:0] oa, ob;
        ia.cmd_valid = 3'b111; ia.cmd_we = '0; ia.cmd_addr = '0; ia.cmd_len = '0;
        ia.wr_valid = '0; ia.wr_data = '0;
        ib.cmd_valid = 3'b111; ib.cmd_we = '0; ib.cmd_addr = '0; ib.cmd_len = '0;
        ib.wr_valid = '0; ib.wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        oa = {ia.cmd_ready, ia.wr_ready, ia.rd_valid, ia.rd_last, ia.rd_data, ia.mem_en, ia.mem_we,
              ia.mem_addr, ia.mem_wdata, ia.busy, ia.owner, ia.err_tmo};
        ob = {ib.cmd_ready, ib.wr_ready, ib.rd_valid, ib.rd_last, ib.rd_data, ib.mem_en, ib.mem_we,
              ib.mem_addr, ib.mem_wdata, ib.busy, ib.owner, ib.err_tmo};
        checks++; if (oa !== '0) $display("FAIL reset_outputs_a got %h exp 0", oa); else passed++;
        checks++; if (ob !== '0) $display("FAIL reset_outputs_b got %h exp 0", ob); else passed++;
        ia.cmd_valid = '0; ib.cmd_valid = '0;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_prio;
        logic [16:0] got, exp;
        @(negedge clk);
        set_cmd_a(0, 1'b0, 9'h010, 9'd3);
        set_cmd_a(1, 1'b0, 9'h040, 9'd0);
        ia.cmd_valid = 3'b011;
        #1;
        checks++; if (ia.cmd_ready !== 3'b001) $display("FAIL fixed_grant0 got %b exp 001", ia.cmd_ready); else passed++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) ia.cmd_valid = 3'b010;
            #1;
            got = {ia.cmd_ready, ia.owner, ia.mem_en, ia.mem_we, ia.mem_addr};
            exp = {3'b000, 3'b001, 1'b1, 1'b0, AW'(9'h010 + c - 1)};
            checks++; if (got !== exp) $display("FAIL fixed_issue c%0d got %h exp %h", c, got, exp); else passed++;
            if (c >= 2) begin
                checks++;
                if ({ia.rd_valid, ia.rd_last, ia.rd_data} !== {3'b001, 1'b0, pat(AW'(9'h010 + c - 2))})
                    $display("FAIL fixed_rdata c%0d got %b %b %h", c, ia.rd_valid, ia.rd_last, ia.rd_data);
                else passed++;
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({ia.cmd_ready, ia.busy, ia.mem_en, ia.rd_valid, ia.rd_last, ia.rd_data} !== {3'b010, 1'b0, 1'b0, 3'b001, 1'b1, pat(9'h013)})
            $display("FAIL fixed_bubble got rdy %b busy %b en %b rv %b rl %b rd %h", ia.cmd_ready, ia.busy, ia.mem_en, ia.rd_valid, ia.rd_last, ia.rd_data);
        else passed++;
        @(negedge clk);
        ia.cmd_valid = '0;
        #1;
        checks++;
        if ({ia.owner, ia.mem_addr, ia.rd_valid} !== {3'b010, 9'h040, 3'b000})
            $display("FAIL fixed_ch1_issue got owner %b addr %h rv %b", ia.owner, ia.mem_addr, ia.rd_valid);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({ia.rd_valid, ia.rd_last, ia.rd_data, ia.busy} !== {3'b010, 1'b1, pat(9'h040), 1'b0})
            $display("FAIL fixed_ch1_return got rv %b rl %b rd %h busy %b", ia.rd_valid, ia.rd_last, ia.rd_data, ia.busy);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_write_wrap;
        bit gap [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int beat = 0;
        int start;
        @(negedge clk);
        set_cmd_a(2, 1'b1, 9'h1FE, 9'd3);
        ia.cmd_valid = 3'b100;
        #1;
        checks++; if (ia.cmd_ready !== 3'b100) $display("FAIL wr_grant got %b exp 100", ia.cmd_ready); else passed++;
        start = wr_cnt_a;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ia.cmd_valid = '0;
            ia.wr_valid = {gap[c], 1'b0, 1'b1};
            ia.wr_data[2*DW +: DW] = 32'hB000_0000 + beat;
            ia.wr_data[0 +: DW] = 32'hDEAD_BEEF;
            #1;
            checks++;
            if ({ia.wr_ready, ia.mem_en, ia.mem_we} !== {3'b100, gap[c], gap[c]})
                $display("FAIL wr_strobe c%0d got rdy %b en %b we %b", c, ia.wr_ready, ia.mem_en, ia.mem_we);
            else passed++;
            if (gap[c]) begin
                checks++;
                if ({ia.mem_addr, ia.mem_wdata} !== {AW'(9'h1FE + beat), 32'hB000_0000 + 32'(beat)})
                    $display("FAIL wr_beat%0d got addr %h data %h", beat, ia.mem_addr, ia.mem_wdata);
                else passed++;
                beat++;
            end
        end
        @(negedge clk);
        ia.wr_valid = '0;
        #1;
        checks++; if (ia.busy !== 1'b0) $display("FAIL wr_done_busy got %b exp 0", ia.busy); else passed++;
        checks++; if (wr_cnt_a - start !== 4) $display("FAIL wr_count got %0d exp 4", wr_cnt_a - start); else passed++;
    endtask

    task automatic test_watchdog;
        int start;
        @(negedge clk);
        set_cmd_a(1, 1'b1, 9'h080, 9'd7);
        ia.cmd_valid = 3'b010;
        #1;
        checks++; if (ia.cmd_ready !== 3'b010) $display("FAIL wd_grant got %b exp 010", ia.cmd_ready); else passed++;
        start = wr_cnt_a;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ia.cmd_valid = '0;
            ia.wr_valid = (c <= 2) ? 3'b010 : 3'b000;
            #1;
            checks++;
            if ({ia.busy, ia.err_tmo, ia.mem_en} !== {1'b1, 1'b0, (c <= 2)})
                $display("FAIL wd_cycle c%0d got busy %b err %b en %b", c, ia.busy, ia.err_tmo, ia.mem_en);
            else passed++;
        end
        @(negedge clk); #1;
        checks++;
        if ({ia.err_tmo, ia.busy} !== 2'b10) $display("FAIL wd_abort got err %b busy %b exp 1 0", ia.err_tmo, ia.busy);
        else passed++;
        @(negedge clk); #1;
        checks++; if (ia.err_tmo !== 1'b0) $display("FAIL wd_pulse got %b exp 0", ia.err_tmo); else passed++;
        checks++; if (wr_cnt_a - start !== 2) $display("FAIL wd_written got %0d exp 2", wr_cnt_a - start); else passed++;
    endtask

    task automatic test_rr_order;
        logic [2:0] exp_rdy [11] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                                     3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        @(negedge clk);
        for (int ch = 0; ch < NC; ch++) set_cmd_b(ch, 1'b0, AW'(9'h0A0 + ch), 9'd0);
        ib.cmd_valid = 3'b111;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (ib.cmd_ready !== exp_rdy[c]) $display("FAIL rr_order c%0d got %b exp %b", c, ib.cmd_ready, exp_rdy[c]);
            else passed++;
        end
        @(negedge clk);
        ib.cmd_valid = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_rd_lat;
        logic [2:0]    exp_rdy [9] = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [2:0]    exp_rv  [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b001, 3'b000};
        logic          exp_rl  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0] exp_ra  [9] = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h020, 9'h021, 9'h0, 9'h030, 9'h0};
        @(negedge clk);
        set_cmd_b(1, 1'b0, 9'h020, 9'd1);
        set_cmd_b(0, 1'b0, 9'h030, 9'd0);
        ib.cmd_valid = 3'b010;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) ib.cmd_valid = 3'b001;
            if (c == 4) ib.cmd_valid = 3'b000;
            #1;
            checks++;
            if ({ib.cmd_ready, ib.rd_valid, ib.rd_last} !== {exp_rdy[c], exp_rv[c], exp_rl[c]})
                $display("FAIL lat3_route c%0d got rdy %b rv %b rl %b exp %b %b %b", c, ib.cmd_ready, ib.rd_valid, ib.rd_last,
                         exp_rdy[c], exp_rv[c], exp_rl[c]);
            else passed++;
            if (exp_rv[c] != 3'b000) begin
                checks++;
                if (ib.rd_data !== pat(exp_ra[c])) $display("FAIL lat3_data c%0d got %h exp %h", c, ib.rd_data, pat(exp_ra[c]));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [89:0] ob;
        @(negedge clk);
        set_cmd_b(2, 1'b0, 9'h050, 9'd7);
        ib.cmd_valid = 3'b100;
        #1;
        checks++; if (ib.cmd_ready !== 3'b100) $display("FAIL rst_grant got %b exp 100", ib.cmd_ready); else passed++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ib.cmd_valid = '0;
            #1;
            checks++;
            if ({ib.mem_en, ib.mem_addr} !== {1'b1, AW'(9'h050 + c - 1)})
                $display("FAIL rst_issue c%0d got en %b addr %h", c, ib.mem_en, ib.mem_addr);
            else passed++;
        end
        rst_b = 1'b1;
        @(negedge clk); #1;
        ob = {ib.cmd_ready, ib.wr_ready, ib.rd_valid, ib.rd_last, ib.rd_data, ib.mem_en, ib.mem_we,
              ib.mem_addr, ib.mem_wdata, ib.busy, ib.owner, ib.err_tmo};
        checks++; if (ob !== '0) $display("FAIL rst_mid_outputs got %h exp 0", ob); else passed++;
        rst_b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({ib.rd_valid, ib.busy} !== 4'b0) $display("FAIL rst_no_return c%0d got rv %b busy %b", c, ib.rd_valid, ib.busy);
            else passed++;
        end
        @(negedge clk);
        set_cmd_b(0, 1'b0, 9'h060, 9'd0);
        set_cmd_b(2, 1'b0, 9'h070, 9'd0);
        ib.cmd_valid = 3'b101;
        #1;
        checks++; if (ib.cmd_ready !== 3'b001) $display("FAIL rst_ptr_cleared got %b exp 001", ib.cmd_ready); else passed++;
        @(negedge clk);
        ib.cmd_valid = '0;
        #1;
        checks++;
        if ({ib.owner, ib.mem_addr} !== {3'b001, 9'h060}) $display("FAIL rst_new_burst got owner %b addr %h", ib.owner, ib.mem_addr);
        else passed++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_write_wrap();
        test_watchdog();
        test_rr_order();
        test_rd_lat();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
